// File: rtl/abs_diff_pkg.sv
// Shared definitions for the absolute-difference error sweep: FSM state
// encoding, sweep length and the split of the 4-bit stimulus vector into
// the two 2-bit operands a = {in1,in0}, b = {in3,in2}.
package abs_diff_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } sweep_state_e;

  localparam int VEC_W    = 4;
  localparam int OP_W     = 2;
  localparam int A_LSB    = 0;
  localparam int B_LSB    = 2;
  localparam int N_VEC    = 16;
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(N_VEC - 1);

  // Operand a occupies vec[1:0] (in1 is the MSB).
  function automatic logic [OP_W-1:0] op_a(input logic [VEC_W-1:0] v);
    return v[A_LSB +: OP_W];
  endfunction

  // Operand b occupies vec[3:2] (in3 is the MSB).
  function automatic logic [OP_W-1:0] op_b(input logic [VEC_W-1:0] v);
    return v[B_LSB +: OP_W];
  endfunction

endpackage

// File: rtl/abs_diff_exact.sv
// Exact |a-b| of the two 2-bit operands packed in a 4-bit vector,
// zero-extended to OUT_W bits. Purely combinational so it can serve as a
// golden reference next to the approximate circuit under test.
module abs_diff_exact
  import abs_diff_pkg::*;
#(
  parameter int OUT_W = 3
) (
  input  logic [VEC_W-1:0] vec_i,
  output logic [OUT_W-1:0] exact_o
);

  logic [OP_W-1:0] a_w;
  logic [OP_W-1:0] b_w;
  logic [OP_W-1:0] diff_w;

  // Subtract the smaller operand from the larger so no sign handling is needed.
  always_comb begin
    a_w    = op_a(vec_i);
    b_w    = op_b(vec_i);
    diff_w = (a_w >= b_w) ? (a_w - b_w) : (b_w - a_w);
    exact_o = OUT_W'(diff_w);
  end

endmodule

// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error sweep of a 2-bit absolute-difference approximate circuit.
// On start the block walks all 16 input vectors; each vector is driven for
// one cycle (DRIVE) and the combinational response is captured in the next
// (SAMPLE). Max error, summed error and miss count are accumulated, and a
// pass flag (max error <= ET) is produced when the sweep completes.
//
// Handshake: start is a single-cycle request honoured only in IDLE; busy is
// high while the sweep runs; done is a one-cycle pulse in DONE, at which
// point max_err/sum_err/n_miss/pass are valid and they hold until the next
// accepted start. All outputs come from registers (approx never reaches an
// output combinationally).
module abs_diff_err_sweep
  import abs_diff_pkg::*;
#(
  parameter int ET    = 3,
  parameter int OUT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [3:0]       vec,
  input  logic [OUT_W-1:0] approx,
  output logic             busy,
  output logic             done,
  output logic [OUT_W:0]   max_err,
  output logic [OUT_W+4:0] sum_err,
  output logic [4:0]       n_miss,
  output logic             pass,
  output logic [1:0]       dbg_state
);

  localparam logic [OUT_W:0] ET_V = (OUT_W + 1)'(ET);

  sweep_state_e state_q, state_d;

  logic [VEC_W-1:0] idx_q,  idx_d;
  logic [VEC_W-1:0] vec_q,  vec_d;
  logic [OUT_W:0]   max_q,  max_d;
  logic [OUT_W+4:0] sum_q,  sum_d;
  logic [4:0]       miss_q, miss_d;
  logic             pass_q, pass_d;

  logic [OUT_W-1:0] exact_w;
  logic [OUT_W:0]   exact_ext_w;
  logic [OUT_W:0]   approx_ext_w;
  logic [OUT_W:0]   err_w;
  logic [OUT_W:0]   max_new_w;

  // Golden response for the vector currently on the bus.
  abs_diff_exact #(
    .OUT_W (OUT_W)
  ) u_exact (
    .vec_i   (vec_q),
    .exact_o (exact_w)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: IDLE waits for start, DRIVE/SAMPLE alternate per vector.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_DRIVE;
      ST_DRIVE:  state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = (idx_q == LAST_IDX) ? ST_DONE : ST_DRIVE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    busy      = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE);
    done      = (state_q == ST_DONE);
    dbg_state = state_q;
  end

  // Absolute error between exact and approximate response, one bit wider
  // than the bus so the full range is kept.
  always_comb begin
    exact_ext_w  = {1'b0, exact_w};
    approx_ext_w = {1'b0, approx};
    err_w        = (exact_ext_w >= approx_ext_w) ? (exact_ext_w - approx_ext_w)
                                                 : (approx_ext_w - exact_ext_w);
    max_new_w    = (err_w > max_q) ? err_w : max_q;
  end

  // Datapath next state: clear on accepted start, accumulate in SAMPLE.
  always_comb begin
    idx_d  = idx_q;
    vec_d  = vec_q;
    max_d  = max_q;
    sum_d  = sum_q;
    miss_d = miss_q;
    pass_d = pass_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d  = '0;
          vec_d  = '0;
          max_d  = '0;
          sum_d  = '0;
          miss_d = '0;
          pass_d = 1'b0;
        end
      end
      ST_SAMPLE: begin
        max_d  = max_new_w;
        sum_d  = sum_q + (OUT_W + 5)'(err_w);
        miss_d = miss_q + {4'd0, (err_w != '0)};
        idx_d  = idx_q + 1'b1;
        // Keep the last vector on the bus once the sweep is over; decide
        // pass here so it is already valid while done is high.
        if (idx_q == LAST_IDX) pass_d = (max_new_w <= ET_V);
        else                   vec_d  = idx_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q  <= '0;
      vec_q  <= '0;
      max_q  <= '0;
      sum_q  <= '0;
      miss_q <= '0;
      pass_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      vec_q  <= vec_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      miss_q <= miss_d;
      pass_q <= pass_d;
    end
  end

  assign vec     = vec_q;
  assign max_err = max_q;
  assign sum_err = sum_q;
  assign n_miss  = miss_q;
  assign pass    = pass_q;

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Directed bench for abs_diff_err_sweep: a table of approximate-circuit
// behaviours (golden loopback or constant output) with hand-computed sweep
// results, plus sequences for mid-sweep reset and ignored start pulses.
module tb_abs_diff_err_sweep;

  localparam int OUT_W = 3;
  localparam int ET    = 3;
  localparam int LAT   = 32;   // edges from the accepting edge to done

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [3:0]       vec;
  logic [OUT_W-1:0] approx;
  logic             busy;
  logic             done;
  logic [OUT_W:0]   max_err;
  logic [OUT_W+4:0] sum_err;
  logic [4:0]       n_miss;
  logic             pass;
  logic [1:0]       dbg_state;

  int checks   = 0;
  int failures = 0;

  // approximate-circuit emulation
  logic             golden_mode;
  logic [OUT_W-1:0] const_val;

  typedef struct {
    logic             golden;
    logic [OUT_W-1:0] cval;
    int               exp_max;
    int               exp_sum;
    int               exp_miss;
    int               exp_pass;
  } vec_t;

  vec_t tbl[7];

  abs_diff_err_sweep #(.ET(ET), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .vec       (vec),
    .approx    (approx),
    .busy      (busy),
    .done      (done),
    .max_err   (max_err),
    .sum_err   (sum_err),
    .n_miss    (n_miss),
    .pass      (pass),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [OUT_W-1:0] model_abs(input logic [3:0] v);
    int a, b;
    a = v[1:0];
    b = v[3:2];
    return OUT_W'((a > b) ? a - b : b - a);
  endfunction

  always_comb approx = golden_mode ? model_abs(vec) : const_val;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_results(input string tag, input int mx, input int sm,
                             input int ms, input int ps);
    chk({tag, ".max_err"}, int'(max_err), mx);
    chk({tag, ".sum_err"}, int'(sum_err), sm);
    chk({tag, ".n_miss"},  int'(n_miss),  ms);
    chk({tag, ".pass"},    int'(pass),    ps);
  endtask

  // Pulse start at a quiet point; returns after the accepting edge (+1).
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait for done after an accepted start; reports edges waited and
  // whether vec followed the index during the sweep.
  task automatic wait_done(output int edges, output bit vec_ok);
    edges  = 0;
    vec_ok = 1'b1;
    if (vec !== 4'd0) vec_ok = 1'b0;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (edges < LAT && vec !== 4'(edges / 2)) vec_ok = 1'b0;
    end
  endtask

  initial begin
    int  edges;
    bit  vec_ok;
    bit  seen_done;
    logic [OUT_W:0]   hold_max;
    logic [OUT_W+4:0] hold_sum;

    // golden: |a-b| histogram 0:4 1:6 2:4 3:2
    tbl[0] = '{1'b1, 3'd0, 0, 0,  0,  1};
    tbl[1] = '{1'b0, 3'd0, 3, 20, 12, 1};
    tbl[2] = '{1'b0, 3'd2, 2, 16, 12, 1};
    tbl[3] = '{1'b0, 3'd7, 7, 92, 16, 0};
    tbl[4] = '{1'b0, 3'd1, 2, 12, 10, 1};
    tbl[5] = '{1'b0, 3'd3, 3, 28, 14, 1};   // max exactly at threshold
    tbl[6] = '{1'b0, 3'd4, 4, 44, 16, 0};   // one above threshold

    golden_mode = 1'b1;
    const_val   = '0;
    start       = 1'b0;
    rst_n       = 1'b0;
    #1;
    chk("rst.busy", int'(busy), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.vec",  int'(vec),  0);
    chk_results("rst", 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // table-driven sweeps
    for (int i = 0; i < 7; i++) begin
      golden_mode = tbl[i].golden;
      const_val   = tbl[i].cval;
      pulse_start();
      chk($sformatf("t%0d.busy_after_start", i), int'(busy), 1);
      wait_done(edges, vec_ok);
      chk($sformatf("t%0d.done_latency", i), edges, LAT);
      chk($sformatf("t%0d.vec_tracks_index", i), int'(vec_ok), 1);
      chk($sformatf("t%0d.busy_in_done", i), int'(busy), 0);
      chk_results($sformatf("t%0d", i), tbl[i].exp_max, tbl[i].exp_sum,
                  tbl[i].exp_miss, tbl[i].exp_pass);
      @(posedge clk); #1;
      chk($sformatf("t%0d.done_one_cycle", i), int'(done), 0);
      chk_results($sformatf("t%0d.hold", i), tbl[i].exp_max, tbl[i].exp_sum,
                  tbl[i].exp_miss, tbl[i].exp_pass);
      repeat (2) @(posedge clk); #1;
    end

    // mid-sweep reset: abort, outputs clear immediately, no done later
    golden_mode = 1'b0;
    const_val   = 3'd7;
    pulse_start();
    repeat (9) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort.busy", int'(busy), 0);
    chk("abort.done", int'(done), 0);
    chk("abort.vec",  int'(vec),  0);
    chk_results("abort", 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("abort.no_activity", int'(seen_done), 0);
    pulse_start();
    wait_done(edges, vec_ok);
    chk("abort.resweep_latency", edges, LAT);
    chk_results("abort.resweep", 7, 92, 16, 0);
    repeat (2) @(posedge clk); #1;

    // start re-pulsed mid-sweep and coincident with done is ignored
    const_val = 3'd0;
    pulse_start();
    repeat (4) @(posedge clk); #1;
    pulse_start();
    edges = 5;
    vec_ok = 1'b1;
    while (done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("repulse.done_latency", edges, LAT);
    chk_results("repulse", 3, 20, 12, 1);
    hold_max = max_err;
    hold_sum = sum_err;
    start = 1'b1;                  // coincident with DONE
    @(posedge clk); #1;
    start = 1'b0;
    chk("repulse.idle_busy", int'(busy), 0);
    chk("repulse.idle_done", int'(done), 0);
    seen_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen_done = 1'b1;
    end
    chk("repulse.single_done", int'(seen_done), 0);
    chk("repulse.hold_max", int'(max_err), int'(hold_max));
    chk("repulse.hold_sum", int'(sum_err), int'(hold_sum));
    chk_results("repulse.hold", 3, 20, 12, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
